slot_access_scheduler: RTL and testbench

//  Sequences save/load traffic between the menu FSM and the shared single-port save-slot RAM (3 slots x DATA_W).

---
 rtl/slot_access_scheduler.sv | 170 +++++++++++++++++
 tb/tb_slot_access_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/slot_access_scheduler.sv
// slot_access_scheduler
//  Converts the menu's held save/load slot codes into one-shot requests, keeps
//  one pending save and one pending load, and sequences them onto the shared
//  single-port save-slot RAM. Save wins arbitration; a save followed by a load
//  is served back to back, so the load sees the freshly written word.
//  Optional build macro SLOT_SYNC_VS_EN: RAM traffic only starts on a
//  synchronized falling edge of iVS (frame start). When it is undefined, iVS is ignored.
module slot_access_scheduler #(
   parameter int DATA_W    = 32,
   parameter int NUM_SLOTS = 3
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   input  logic [31:0]       save_slot,
   input  logic [31:0]       load_slot,
   input  logic [DATA_W-1:0] save_data,
   input  logic              iVS,
   output logic [1:0]        mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              busy,
   output logic              err_slot
);

   typedef enum logic [2:0] {
      IDLE, WAIT_WIN, WRITE, RD_ADDR, RD_WAIT, RD_CAP
   } state_t;

   state_t              state_q;
   logic [31:0]         save_code_q, save_prev_q, load_code_q, load_prev_q;
   logic                save_pend_q, load_pend_q;
   logic [1:0]          save_idx_q, load_idx_q;
   logic [DATA_W-1:0]   save_dat_q;
   logic [1:0]          mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q, load_data_q;
   logic                mem_we_q, load_valid_q, err_q;
   logic                save_chg, load_chg, save_fire, load_fire, bad_fire;
   logic                save_take, load_take, win;

   // A code fires once when it changes to a nonzero value; illegal codes only flag an error
   assign save_chg  = (save_code_q != save_prev_q) && (save_code_q != 32'd0);
   assign load_chg  = (load_code_q != load_prev_q) && (load_code_q != 32'd0);
   assign save_fire = save_chg && (save_code_q <= 32'(NUM_SLOTS));
   assign load_fire = load_chg && (load_code_q <= 32'(NUM_SLOTS));
   assign bad_fire  = (save_chg && !save_fire) || (load_chg && !load_fire);

`ifdef SLOT_SYNC_VS_EN
   logic [2:0] vs_sync_q;

   // Two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) vs_sync_q <= 3'b111;
      else         vs_sync_q <= {vs_sync_q[1:0], iVS};
   end

   assign win = vs_sync_q[2] & ~vs_sync_q[1];
`else
   logic unused_vs;
   assign unused_vs = iVS;
   assign win       = 1'b1;
`endif

   // Pending flags are released when service starts so requests arriving mid-service queue up
   assign save_take = (state_q == WAIT_WIN) && win && save_pend_q;
   assign load_take = ((state_q == WAIT_WIN) && win && !save_pend_q && load_pend_q) ||
                      ((state_q == WRITE) && load_pend_q);

   // Slot-code history registers used for change detection
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         save_code_q <= '0;
         save_prev_q <= '0;
         load_code_q <= '0;
         load_prev_q <= '0;
         err_q       <= 1'b0;
      end else begin
         save_code_q <= save_slot;
         save_prev_q <= save_code_q;
         load_code_q <= load_slot;
         load_prev_q <= load_code_q;
         err_q       <= bad_fire;
      end
   end

   // Single-entry pending save/load; a newer request of the same type overwrites
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         save_pend_q <= 1'b0;
         save_idx_q  <= '0;
         save_dat_q  <= '0;
         load_pend_q <= 1'b0;
         load_idx_q  <= '0;
      end else begin
         if (save_fire) begin
            save_pend_q <= 1'b1;
            save_idx_q  <= 2'(save_code_q - 32'd1);
            save_dat_q  <= save_data;
         end else if (save_take) begin
            save_pend_q <= 1'b0;
         end
         if (load_fire) begin
            load_pend_q <= 1'b1;
            load_idx_q  <= 2'(load_code_q - 32'd1);
         end else if (load_take) begin
            load_pend_q <= 1'b0;
         end
      end
   end

   // Access sequencer with registered RAM/return outputs
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q      <= IDLE;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
      end else begin
         mem_we_q     <= 1'b0;
         load_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (save_pend_q || load_pend_q) state_q <= WAIT_WIN;
            end
            WAIT_WIN: begin
               if (win) begin
                  if (save_pend_q) begin
                     state_q     <= WRITE;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= save_idx_q;
                     mem_wdata_q <= save_dat_q;
                  end else begin
                     state_q    <= RD_ADDR;
                     mem_addr_q <= load_idx_q;
                  end
               end
            end
            WRITE: begin
               if (load_pend_q) begin
                  state_q    <= RD_ADDR;
                  mem_addr_q <= load_idx_q;
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_ADDR: state_q <= RD_WAIT;
            RD_WAIT: begin
               state_q      <= RD_CAP;
               load_data_q  <= mem_rdata;
               load_valid_q <= 1'b1;
            end
            RD_CAP:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign err_slot   = err_q;
   assign busy       = (state_q != IDLE) | save_pend_q | load_pend_q;

endmodule

// File: tb/tb_slot_access_scheduler.sv
// Scoreboard bench for slot_access_scheduler: the stimulus side predicts
// each RAM write, load return and error pulse (with its cycle) from the slot
// rules; a monitor pops and compares whenever the DUT presents one.
module tb_slot_access_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] save_slot, load_slot, save_data, mem_rdata, mem_wdata, load_data;
   logic        iVS, mem_we, load_valid, busy, err_slot;
   logic [1:0]  mem_addr;

   slot_access_scheduler #(.DATA_W(32), .NUM_SLOTS(3)) dut (
      .iVGA_CLK(clk), .iRST_n(rst_n), .save_slot(save_slot), .load_slot(load_slot),
      .save_data(save_data), .iVS(iVS), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata), .load_data(load_data),
      .load_valid(load_valid), .busy(busy), .err_slot(err_slot)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // registered single-port RAM
   logic [31:0] ram [4];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   typedef struct { logic [1:0] addr; logic [31:0] data; int cyc; } wr_t;
   typedef struct { logic [31:0] data; int cyc; } ld_t;
   wr_t exp_wr[$];
   ld_t exp_ld[$];
   int  exp_err[$];

   logic [31:0] ref_ram [4];
   logic [31:0] last_s, last_l;
   int nchk = 0, nerr = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      iVS = 1'($urandom_range(0, 1));
   endtask

   // Drive new codes at a negedge and predict what they cause
   task automatic drive(logic [31:0] s, logic [31:0] l, logic [31:0] d);
      int k;
      bit sf, lf, bad;
      wr_t w;
      ld_t r;
      k = cyc;
      save_slot = s; load_slot = l; save_data = d;
      sf  = (s != last_s) && (s != 0) && (s <= 3);
      lf  = (l != last_l) && (l != 0) && (l <= 3);
      bad = ((s != last_s) && (s > 3)) || ((l != last_l) && (l > 3));
      if (sf) begin
         ref_ram[s-1] = d;
         w.addr = 2'(s - 1); w.data = d; w.cyc = k + 4;
         exp_wr.push_back(w);
      end
      if (lf) begin
         r.data = ref_ram[l-1]; r.cyc = sf ? k + 7 : k + 6;
         exp_ld.push_back(r);
      end
      if (bad) exp_err.push_back(k + 2);
      last_s = s; last_l = l;
   endtask

   task automatic gap(int n);
      repeat (n) tick();
      chk("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic reset_on();
      rst_n = 1'b0;
      exp_wr.delete(); exp_ld.delete(); exp_err.delete();
      last_s = '0; last_l = '0;
   endtask

   // Monitor: sample after each rising edge settles
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         chk("rst_ctrl", 64'({mem_we, load_valid, busy, err_slot, mem_addr}), 64'd0);
         chk("rst_data", {mem_wdata, load_data}, 64'd0);
      end else begin
         if (mem_we) begin
            if (exp_wr.size() == 0) chk("we_unexpected", 64'(mem_we), 64'd0);
            else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", 64'(mem_addr), 64'(w.addr));
               chk("wr_data", 64'(mem_wdata), 64'(w.data));
               chk("wr_cycle", 64'(cyc), 64'(w.cyc));
            end
         end
         if (load_valid) begin
            if (exp_ld.size() == 0) chk("lv_unexpected", 64'(load_valid), 64'd0);
            else begin
               ld_t r;
               r = exp_ld.pop_front();
               chk("ld_data", 64'(load_data), 64'(r.data));
               chk("ld_cycle", 64'(cyc), 64'(r.cyc));
            end
         end
         if (err_slot) begin
            if (exp_err.size() == 0) chk("err_unexpected", 64'(err_slot), 64'd0);
            else chk("err_cycle", 64'(cyc), 64'(exp_err.pop_front()));
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         ram[i] = $urandom;
         ref_ram[i] = ram[i];
      end
      save_slot = '0; load_slot = '0; save_data = '0; iVS = 1'b1;
      reset_on();
      repeat (3) tick();
      rst_n = 1'b1;
      gap(4);

      // save code held through reset: one write after release
      reset_on();
      save_slot = 32'd2; save_data = 32'hCAFE_0002;
      repeat (4) tick();
      rst_n = 1'b1;
      drive(32'd2, 32'd0, 32'hCAFE_0002);
      gap(12);

      // load 0->3 held for 100 cycles: single return
      drive(32'd2, 32'd3, $urandom);
      gap(100);

      // save and load of slot 1 in the same cycle
      drive(32'd0, 32'd0, $urandom);
      gap(4);
      drive(32'd1, 32'd1, 32'h0000_A5A5);
      gap(12);

      // illegal save code
      drive(32'd7, 32'd1, $urandom);
      gap(12);

      // reset while the read is in flight, then normal service
      drive(32'd0, 32'd0, $urandom);
      gap(4);
      drive(32'd0, 32'd3, $urandom);
      repeat (5) tick();
      reset_on();
      load_slot = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      gap(4);
      drive(32'd0, 32'd2, $urandom);
      gap(12);

      // randomized operations
      for (int n = 0; n < 60; n++) begin
         logic [31:0] s, l;
         s = last_s; l = last_l;
         case ($urandom_range(0, 6))
            0: s = $urandom_range(1, 3);
            1: l = $urandom_range(1, 3);
            2: begin s = $urandom_range(1, 3); l = $urandom_range(1, 3); end
            3: s = $urandom_range(4, 1000);
            4: l = $urandom_range(4, 1000);
            5: if ($urandom_range(0, 1) == 1) s = '0; else l = '0;
            default: ;
         endcase
         drive(s, l, $urandom);
         gap(12);
      end

      chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      chk("ld_queue_empty", 64'(exp_ld.size()), 64'd0);
      chk("err_queue_empty", 64'(exp_err.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
